// File: rtl/ttl_quad_gate_tester_pkg.sv
// Shared types and constants for the quad 2-input gate tester: sweep states,
// last-vector marker and truth tables for the common 74xx quad gates.
package tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] VEC_LAST = 8'hFF;

    // Indexed as truth[{b,a}]
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/ttl_quad_gate_tester_gate_expect.sv
// Combinational expected-output generator: looks up each gate's pin pair
// in the programmable truth table.
module gate_expect (
    input  logic [7:0] drv,
    input  logic [3:0] truth,
    output logic [3:0] expected
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gate
            assign expected[gi] = truth[drv[2*gi+1 -: 2]];
        end
    endgenerate

endmodule

// File: rtl/ttl_quad_gate_tester.sv
// Sweeps all 256 input-pin combinations of a quad 2-input gate chip and
// checks its outputs. Define TESTER_SENSE_SYNC_EN to double-flop sense.
module ttl_quad_gate_tester
    import tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [3:0] truth,
    output logic [7:0] drv,
    input  logic [3:0] sense,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [7:0] first_fail_vec,
    output logic [8:0] fail_count
);

`ifdef TESTER_SENSE_SYNC_EN
    // Two extra settle cycles cover the synchronizer latency
    localparam int SETTLE_TOTAL = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_TOTAL = SETTLE_CYCLES;
`endif
    localparam int CNT_W = $clog2(SETTLE_TOTAL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_TOTAL - 1);

    state_t           state_q, state_d;
    logic [7:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fail_mask_q, fail_mask_d;
    logic [7:0]       first_fail_q, first_fail_d;
    logic [8:0]       fail_count_q, fail_count_d;
    logic [3:0]       expected;
    logic [3:0]       sense_use;
    logic [3:0]       mismatch;

`ifdef TESTER_SENSE_SYNC_EN
    logic [3:0] sense_meta_q, sense_meta_d;
    logic [3:0] sense_sync_q, sense_sync_d;

    always_comb begin
        sense_meta_d = sense;
        sense_sync_d = sense_meta_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sense_meta_q <= '0;
            sense_sync_q <= '0;
        end else begin
            sense_meta_q <= sense_meta_d;
            sense_sync_q <= sense_sync_d;
        end
    end

    assign sense_use = sense_sync_q;
`else
    assign sense_use = sense;
`endif

    gate_expect u_expect (
        .drv      (vec_q),
        .truth    (truth),
        .expected (expected)
    );

    assign mismatch = sense_use ^ expected;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        fail_mask_d  = fail_mask_q;
        first_fail_d = first_fail_q;
        fail_count_d = fail_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    vec_d        = '0;
                    cnt_d        = '0;
                    fail_mask_d  = '0;
                    first_fail_d = '0;
                    fail_count_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (|mismatch) begin
                    fail_mask_d  = fail_mask_q | mismatch;
                    fail_count_d = fail_count_q + 9'd1;
                    if (fail_count_q == 9'd0) begin
                        first_fail_d = vec_q;
                    end
                end
                // vec stays at 8'hFF in DONE, which is the required drive
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 8'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            fail_mask_q  <= '0;
            first_fail_q <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            fail_mask_q  <= fail_mask_d;
            first_fail_q <= first_fail_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign drv            = vec_q;
    assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (fail_count_q == 9'd0);
    assign fail_mask      = fail_mask_q;
    assign first_fail_vec = first_fail_q;
    assign fail_count     = fail_count_q;

endmodule

// File: tb/tb_ttl_quad_gate_tester.sv
// Randomized scoreboard bench for ttl_quad_gate_tester with a behavioural
// gate-chip model supporting stuck-at faults on its output pins.
module tb_ttl_quad_gate_tester;
    import tester_pkg::*;

    localparam int SETTLE_CYCLES = 4;
`ifdef TESTER_SENSE_SYNC_EN
    localparam int PER = SETTLE_CYCLES + 3;
`else
    localparam int PER = SETTLE_CYCLES + 1;
`endif
    localparam int SWEEP = 256 * PER;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] truth = TT_OR;
    logic [7:0] drv;
    logic [3:0] sense;
    logic       busy, done, pass;
    logic [3:0] fail_mask;
    logic [7:0] first_fail_vec;
    logic [8:0] fail_count;

    // chip kind: 0 NAND, 1 AND, 2 OR, 3 XOR
    int         chip_kind = 2;
    logic [3:0] stuck0 = 4'h0;
    logic [3:0] stuck1 = 4'h0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int exp_pass;
        int exp_mask;
        int exp_first;
        int exp_count;
        int exp_cycle;
    } sb_t;
    sb_t sb_q[$];

    ttl_quad_gate_tester #(.SETTLE_CYCLES(SETTLE_CYCLES)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .truth          (truth),
        .drv            (drv),
        .sense          (sense),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_mask      (fail_mask),
        .first_fail_vec (first_fail_vec),
        .fail_count     (fail_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [3:0] chip_out(int kind, logic [3:0] s0, logic [3:0] s1,
                                            logic [7:0] v);
        logic [3:0] y;
        int a, b;
        y = '0;
        for (int g = 0; g < 4; g++) begin
            a = int'(v[2*g]);
            b = int'(v[2*g+1]);
            case (kind)
                0:       y[g] = !(a == 1 && b == 1);
                1:       y[g] = (a == 1 && b == 1);
                2:       y[g] = (a == 1 || b == 1);
                default: y[g] = (a != b);
            endcase
        end
        return (y & ~s0) | s1;
    endfunction

    assign sense = chip_out(chip_kind, stuck0, stuck1, drv);

    function automatic sb_t model(int kind, logic [3:0] s0, logic [3:0] s1,
                                  logic [3:0] tt, int done_cyc);
        sb_t r;
        int got, want, mism, idx;
        r.exp_mask = 0; r.exp_first = 0; r.exp_count = 0;
        for (int v = 0; v < 256; v++) begin
            got  = int'(chip_out(kind, s0, s1, v[7:0]));
            want = 0;
            for (int g = 0; g < 4; g++) begin
                idx  = 2 * ((v >> (2*g+1)) & 1) + ((v >> (2*g)) & 1);
                want = want | (((int'(tt) >> idx) & 1) << g);
            end
            mism = got ^ want;
            if (mism != 0) begin
                if (r.exp_count == 0) r.exp_first = v;
                r.exp_count++;
                r.exp_mask = r.exp_mask | mism;
            end
        end
        r.exp_pass  = (r.exp_count == 0) ? 1 : 0;
        r.exp_cycle = done_cyc;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever done rises
    logic done_prev = 1'b0;
    always @(negedge clock) begin : monitor
        sb_t e;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", cyc, e.exp_cycle);
                check("pass", int'(pass), e.exp_pass);
                check("fail_mask", int'(fail_mask), e.exp_mask);
                check("first_fail_vec", int'(first_fail_vec), e.exp_first);
                check("fail_count", int'(fail_count), e.exp_count);
                check("done_drv", int'(drv), 255);
                check("done_busy", int'(busy), 0);
                $display("sweep: kind=%0d truth=%h s0=%h s1=%h -> pass=%0d mask=%h first=%h count=%0d",
                         chip_kind, truth, stuck0, stuck1, pass, fail_mask, first_fail_vec, fail_count);
            end
        end
        done_prev = done;
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_drv"}, int'(drv), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_mask"}, int'(fail_mask), 0);
        check({tag, "_first"}, int'(first_fail_vec), 0);
        check({tag, "_count"}, int'(fail_count), 0);
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        sb_q.push_back(model(chip_kind, stuck0, stuck1, truth, cyc + 1 + SWEEP));
        @(negedge clock);
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_drv", int'(drv), 0);
        check("start_done", int'(done), 0);
        check("start_count", int'(fail_count), 0);
        check("start_mask", int'(fail_mask), 0);
        check("start_first", int'(first_fail_vec), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < SWEEP + 50) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic sweep(int kind, logic [3:0] tt, logic [3:0] s0, logic [3:0] s1);
        chip_kind = kind; truth = tt; stuck0 = s0; stuck1 = s1;
        do_start();
        wait_done();
    endtask

    initial begin
        // Reset beats a simultaneous start
        resetn = 1'b0;
        start  = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        check_reset_outputs("reset");
        resetn = 1'b1;

        sweep(2, TT_OR, 4'h0, 4'h0);
        sweep(2, TT_OR, 4'b0100, 4'h0);
        sweep(2, TT_AND, 4'h0, 4'h0);

        for (int i = 0; i < 3; i++) begin : rand_sweeps
            logic [3:0] s0, s1;
            s0 = 4'($urandom & $urandom);
            s1 = 4'($urandom & $urandom) & ~s0;
            sweep(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), s0, s1);
        end

        // Reset in the middle of a sweep discards everything
        chip_kind = 3; truth = TT_XOR; stuck0 = 4'b0010; stuck1 = 4'h0;
        do_start();
        begin : wait_vec100
            int n = 0;
            while (drv != 8'd100 && n < 101 * PER + 20) begin
                @(negedge clock);
                n++;
            end
        end
        check("reached_vec100", int'(drv), 100);
        resetn = 1'b0;
        @(negedge clock);
        check_reset_outputs("midreset");
        resetn = 1'b1;
        void'(sb_q.pop_back());
        do_start();
        wait_done();

        // start pulses while busy must not disturb the sweep or its timing
        chip_kind = 0; truth = TT_NAND; stuck0 = 4'h0; stuck1 = 4'b1000;
        do_start();
        repeat (300) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("repulse_busy", int'(busy), 1);
        repeat (500) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();

        // Restart straight from DONE
        sweep(1, TT_AND, 4'h0, 4'h0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
